// File: rtl/riscv_sim_host_pkg.sv
// Shared encodings for the RISC-V simulation host controller: FSM states and
// the meaning of the core's CSR status word.
package riscv_sim_host_pkg;

    localparam logic [1:0] ST_RST_SEQ = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int unsigned STATUS_RUNNING = 0;
    localparam int unsigned STATUS_PASS    = 1;

endpackage

// File: rtl/riscv_sim_host_ctrl_if.sv
// Bundle between the bench top (master) and the host controller (slave):
// core status/retire inputs, downstream resets, verdict and statistics.
interface riscv_sim_host_ctrl_if #(
    parameter int P_NUM_DOMAINS = 2,
    parameter int P_CNT_W       = 32,
    parameter int P_STATUS_W    = 32
);
    logic [P_CNT_W-1:0]       max_cycles;
    logic [P_STATUS_W-1:0]    status;
    logic                     inst_retire;
    logic [P_NUM_DOMAINS-1:0] domain_reset;
    logic                     running;
    logic                     done;
    logic                     pass;
    logic                     fail;
    logic                     timeout;
    logic [P_STATUS_W-1:0]    fail_code;
    logic [P_CNT_W-1:0]       num_cycles;
    logic [P_CNT_W-1:0]       num_inst;

    modport slave (
        input  max_cycles, status, inst_retire,
        output domain_reset, running, done, pass, fail, timeout,
               fail_code, num_cycles, num_inst
    );

    modport master (
        output max_cycles, status, inst_retire,
        input  domain_reset, running, done, pass, fail, timeout,
               fail_code, num_cycles, num_inst
    );
endinterface

// File: rtl/riscv_sim_rst_seq.sv
// Staged reset release: domain i drops its reset on edge (i+1)*P_RST_STAGE
// after reset deassertion; seq_done flags the cycle before the last release.
module riscv_sim_rst_seq #(
    parameter int P_NUM_DOMAINS = 2,
    parameter int P_RST_STAGE   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [P_NUM_DOMAINS-1:0] domain_reset,
    output logic                     seq_done
);
    localparam int TOTAL = P_NUM_DOMAINS * P_RST_STAGE;
    localparam int CW    = $clog2(TOTAL + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt  = cnt_q + 1'b1;
    assign seq_done = (cnt_q == CW'(TOTAL - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            domain_reset <= '1;
        end else if (cnt_q != CW'(TOTAL)) begin
            cnt_q <= cnt_nxt;
            for (int i = 0; i < P_NUM_DOMAINS; i++) begin
                if (cnt_nxt == CW'((i + 1) * P_RST_STAGE)) domain_reset[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/riscv_sim_host_ctrl.sv
// Host-side test harness controller: reset sequencing, watchdog and sticky
// verdict. Define RISCV_SIM_HOST_STATS_EN to build the cycle/instruction counters.
module riscv_sim_host_ctrl
    import riscv_sim_host_pkg::*;
#(
    parameter int P_NUM_DOMAINS  = 2,
    parameter int P_RST_STAGE    = 1,
    parameter int P_CNT_W        = 32,
    parameter int P_STATUS_W     = 32,
    parameter int P_DRAIN_CYCLES = 2
) (
    input logic                  clk,
    input logic                  reset,
    riscv_sim_host_ctrl_if.slave host
);
    localparam int DW = (P_DRAIN_CYCLES > 1) ? $clog2(P_DRAIN_CYCLES) : 1;

    logic [1:0]            state_q;
    logic [P_CNT_W-1:0]    wdog_q;
    logic [DW-1:0]         drain_q;
    logic [P_STATUS_W-1:0] fail_code_q;
    logic                  timeout_hit_q;
    logic                  running_q;
    logic                  done_q;
    logic                  pass_q;
    logic                  fail_q;
    logic                  timeout_q;
    logic                  seq_done;

    riscv_sim_rst_seq #(
        .P_NUM_DOMAINS(P_NUM_DOMAINS),
        .P_RST_STAGE  (P_RST_STAGE)
    ) u_rst_seq (
        .clk         (clk),
        .reset       (reset),
        .domain_reset(host.domain_reset),
        .seq_done    (seq_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RST_SEQ;
            wdog_q        <= '0;
            drain_q       <= '0;
            fail_code_q   <= '0;
            timeout_hit_q <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_RST_SEQ: begin
                    if (seq_done) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (~&wdog_q) wdog_q <= wdog_q + 1'b1;
                    // A non-zero status on the expiry edge takes priority over the watchdog.
                    if (host.status != P_STATUS_W'(STATUS_RUNNING)) begin
                        fail_code_q <= host.status;
                        state_q     <= ST_DRAIN;
                        running_q   <= 1'b0;
                    end else if (host.max_cycles != '0 && wdog_q == host.max_cycles) begin
                        timeout_hit_q <= 1'b1;
                        state_q       <= ST_DRAIN;
                        running_q     <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DW'(P_DRAIN_CYCLES - 1)) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        pass_q    <= (fail_code_q == P_STATUS_W'(STATUS_PASS));
                        fail_q    <= (fail_code_q >  P_STATUS_W'(STATUS_PASS));
                        timeout_q <= timeout_hit_q;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign host.running   = running_q;
    assign host.done      = done_q;
    assign host.pass      = pass_q;
    assign host.fail      = fail_q;
    assign host.timeout   = timeout_q;
    assign host.fail_code = fail_code_q;

`ifdef RISCV_SIM_HOST_STATS_EN
    logic [P_CNT_W-1:0] cycles_q;
    logic [P_CNT_W-1:0] inst_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles_q <= '0;
            inst_q   <= '0;
        end else if (state_q == ST_RUN) begin
            if (~&cycles_q) cycles_q <= cycles_q + 1'b1;
            if (host.inst_retire && ~&inst_q) inst_q <= inst_q + 1'b1;
        end
    end

    assign host.num_cycles = cycles_q;
    assign host.num_inst   = inst_q;
`else
    logic unused_inst_retire;
    assign unused_inst_retire = host.inst_retire;
    assign host.num_cycles    = '0;
    assign host.num_inst      = '0;
`endif

endmodule

// File: tb/tb_riscv_sim_host_ctrl.sv
// Scoreboard bench for riscv_sim_host_ctrl: directed and random runs are
// modelled per RUN edge, expected verdicts queued and checked on done.
module tb_riscv_sim_host_ctrl;

    localparam int D   = 2;
    localparam int MAXL = 1100;
`ifdef RISCV_SIM_HOST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        bit          pass;
        bit          fail;
        bit          tmo;
        logic [31:0] code;
        int unsigned cycles;
        int unsigned inst;
        int unsigned done_edge;
    } exp_t;

    logic clk;
    logic reset;
    int unsigned n_edge = 0;
    int n_vec = 0;
    int n_err = 0;
    exp_t sb_q[$];

    logic [31:0] st_a [1:MAXL];
    logic [31:0] mc_a [1:MAXL];
    bit          ir_a [1:MAXL];

    riscv_sim_host_ctrl_if #(.P_NUM_DOMAINS(2), .P_CNT_W(32), .P_STATUS_W(32)) host_if ();

    riscv_sim_host_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .host (host_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) n_edge++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk RUN edges; watchdog count before edge k is k-1.
    function automatic void model(input int len, output exp_t e, output bit hit, output int kx);
        int unsigned n_ir = 0;
        e   = '{default: 0};
        hit = 1'b0;
        kx  = 0;
        for (int k = 1; k <= len; k++) begin
            if (ir_a[k]) n_ir++;
            if (st_a[k] != 0) begin
                hit    = 1'b1;
                e.code = st_a[k];
                e.pass = (st_a[k] == 1);
                e.fail = (st_a[k] > 1);
            end else if (mc_a[k] != 0 && (k - 1) == mc_a[k]) begin
                hit   = 1'b1;
                e.tmo = 1'b1;
            end
            if (hit) begin
                kx       = k;
                e.cycles = STATS ? k : 0;
                e.inst   = STATS ? n_ir : 0;
                break;
            end
        end
    endfunction

    task automatic clear_stim();
        for (int k = 1; k <= MAXL; k++) begin
            st_a[k] = '0;
            mc_a[k] = '0;
            ir_a[k] = 1'b0;
        end
    endtask

    task automatic run_case(input int len, input int abort_k);
        exp_t e;
        bit hit;
        int kx;
        int unsigned rel;
        model(len, e, hit, kx);
        @(negedge clk);
        reset = 1'b0;
        host_if.status      = '0;
        host_if.inst_retire = 1'b0;
        host_if.max_cycles  = '0;
        #1;
        check("rst_domain_reset", host_if.domain_reset, 2'b11);
        check("rst_flags", {host_if.running, host_if.done, host_if.pass, host_if.fail, host_if.timeout}, 5'b0);
        check("rst_fail_code", host_if.fail_code, 0);
        check("rst_stats", {host_if.num_cycles, host_if.num_inst}, 0);
        @(negedge clk);
        reset = 1'b1;
        rel   = n_edge;
        if (hit && abort_k < 0) begin
            e.done_edge = rel + 2 + kx + D;
            sb_q.push_back(e);
        end
        @(negedge clk);
        check("seq_edge1", {host_if.running, host_if.domain_reset}, 3'b010);
        @(negedge clk);
        check("seq_edge2", {host_if.running, host_if.domain_reset}, 3'b100);
        for (int k = 1; k <= len; k++) begin
            host_if.status      = st_a[k];
            host_if.max_cycles  = mc_a[k];
            host_if.inst_retire = ir_a[k];
            @(negedge clk);
            if (k == abort_k) begin
                check("pre_abort_state", {host_if.running, host_if.done}, 2'b00);
                reset = 1'b0;
                #1;
                check("abort_done", host_if.done, 1'b0);
                check("abort_domain_reset", host_if.domain_reset, 2'b11);
                check("abort_fail_code", host_if.fail_code, 0);
                return;
            end
        end
        if (hit) begin
            check("done_seen", sb_q.size(), 0);
            check("sticky_verdict", {host_if.done, host_if.pass, host_if.fail, host_if.timeout},
                  {1'b1, e.pass, e.fail, e.tmo});
            check("sticky_fail_code", host_if.fail_code, e.code);
            check("no_reassert", host_if.domain_reset, 2'b00);
        end else begin
            check("no_exit_state", {host_if.done, host_if.running}, 2'b01);
            check("no_exit_cycles", host_if.num_cycles, STATS ? len : 0);
        end
    endtask

    // Monitor: pops one expectation on every rising done.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit done_prev;
        if (host_if.done === 1'b1 && !done_prev) begin
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("done_edge", n_edge, e.done_edge);
                check("verdict", {host_if.running, host_if.pass, host_if.fail, host_if.timeout},
                      {1'b0, e.pass, e.fail, e.tmo});
                check("fail_code", host_if.fail_code, e.code);
                check("num_cycles", host_if.num_cycles, e.cycles);
                check("num_inst", host_if.num_inst, e.inst);
            end
        end
        done_prev = (host_if.done === 1'b1);
    end

    task automatic gen_random(input int len);
        int unsigned base_mc, mc2, sk;
        int chg;
        logic [31:0] code;
        clear_stim();
        base_mc = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 60);
        mc2     = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 50);
        chg     = $urandom_range(1, len);
        sk      = $urandom_range(3, len + 10);
        case ($urandom_range(0, 2))
            0:       code = 32'd1;
            1:       code = $urandom_range(2, 9);
            default: code = $urandom;
        endcase
        for (int k = 1; k <= len; k++) begin
            ir_a[k] = ($urandom_range(0, 1) == 1);
            mc_a[k] = (k < chg) ? base_mc : mc2;
            st_a[k] = (k == sk) ? code : ((k > sk) ? ($urandom | 32'd1) : 32'd0);
            if (k > len - D - 3) begin
                st_a[k] = '0;
                mc_a[k] = '0;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        host_if.status      = '0;
        host_if.inst_retire = 1'b0;
        host_if.max_cycles  = '0;

        // Pass: 7 retires, status=1 on RUN edge 10; retires afterwards ignored.
        clear_stim();
        for (int k = 2; k <= 8; k++) ir_a[k] = 1'b1;
        st_a[10] = 32'd1;
        for (int k = 11; k <= 30; k++) begin
            ir_a[k] = 1'b1;
            st_a[k] = $urandom_range(0, 7);
        end
        run_case(30, -1);

        // Fail with later status changes.
        clear_stim();
        st_a[15] = 32'd5;
        for (int k = 16; k <= 25; k++) st_a[k] = $urandom | 32'd1;
        for (int k = 1; k <= 40; k++) ir_a[k] = ($urandom_range(0, 1) == 1);
        run_case(40, -1);

        // Timeout at max_cycles=20.
        clear_stim();
        for (int k = 1; k <= 40; k++) begin
            mc_a[k] = 32'd20;
            ir_a[k] = ($urandom_range(0, 1) == 1);
        end
        run_case(40, -1);

        // Watchdog disabled: no exit in 1000 cycles.
        clear_stim();
        for (int k = 1; k <= 1000; k++) ir_a[k] = ($urandom_range(0, 1) == 1);
        run_case(1000, -1);

        // Collision: status=3 on the expiry edge.
        clear_stim();
        for (int k = 1; k <= 40; k++) mc_a[k] = 32'd20;
        st_a[21] = 32'd3;
        run_case(40, -1);

        // Reset while in DRAIN.
        clear_stim();
        st_a[5] = 32'd1;
        run_case(30, 6);

        for (int t = 0; t < 14; t++) begin
            gen_random(80);
            run_case(80, -1);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "time budget exceeded");
    end

endmodule
